addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter.sv | 123 ++++++++++++
 tb/tb_addsub_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one pipelined add/sub unit between two requesters
// Each requester holds at most one operation; results return through a LAT-deep tag pipeline.
module addsub_arbiter #(
    parameter int N   = 8,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_sub,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [N-1:0] rsp0_sum,
    output logic         rsp0_cout,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_sub,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp1_sum,
    output logic         rsp1_cout,
    output logic [N-1:0] u_a,
    output logic [N-1:0] u_b,
    output logic         u_cin,
    input  logic [N-1:0] u_sum,
    input  logic         u_cout
);
    typedef enum logic [1:0] {IDLE, INFLIGHT, DONE} state_t;

    state_t         state0, state1;
    logic           last_grant;
    logic           elig0, elig1, grant0, grant1;
    logic           exit0, exit1;
    logic [LAT-1:0] tag_valid, tag_id, tag_cout;
    logic [N-1:0]   res0_sum, res1_sum;
    logic           res0_cout, res1_cout;

    always_comb begin
        elig0  = !rst && req0_valid && (state0 == IDLE);
        elig1  = !rst && req1_valid && (state1 == IDLE);
        // last_grant=1 means req1 went last, so req0 takes a tie.
        grant0 = elig0 && (!elig1 || last_grant);
        grant1 = elig1 && !grant0;
        exit0  = tag_valid[LAT-1] && !tag_id[LAT-1];
        exit1  = tag_valid[LAT-1] &&  tag_id[LAT-1];
        u_a    = '0;
        u_b    = '0;
        u_cin  = 1'b0;
        if (grant0) begin
            u_a   = req0_a;
            u_b   = req0_b;
            u_cin = req0_sub;
        end else if (grant1) begin
            u_a   = req1_a;
            u_b   = req1_b;
            u_cin = req1_sub;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = !rst && (state0 == DONE);
    assign rsp1_valid = !rst && (state1 == DONE);
    assign rsp0_sum   = rst ? '0 : res0_sum;
    assign rsp1_sum   = rst ? '0 : res1_sum;
    assign rsp0_cout  = !rst && res0_cout;
    assign rsp1_cout  = !rst && res1_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state0     <= IDLE;
            state1     <= IDLE;
            last_grant <= 1'b1;
            tag_valid  <= '0;
            tag_id     <= '0;
            tag_cout   <= '0;
            res0_sum   <= '0;
            res1_sum   <= '0;
            res0_cout  <= 1'b0;
            res1_cout  <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                last_grant <= grant1;
            end
            // The unit does not pipeline its carry, so it rides along with the tag.
            tag_valid[0] <= grant0 || grant1;
            tag_id[0]    <= grant1;
            tag_cout[0]  <= u_cout;
            for (int i = 1; i < LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
                tag_cout[i]  <= tag_cout[i-1];
            end

            case (state0)
                IDLE:     if (grant0) state0 <= INFLIGHT;
                INFLIGHT: if (exit0) begin
                    state0    <= DONE;
                    res0_sum  <= u_sum;
                    res0_cout <= tag_cout[LAT-1];
                end
                DONE:     if (rsp0_ready) state0 <= IDLE;
                default:  state0 <= IDLE;
            endcase

            case (state1)
                IDLE:     if (grant1) state1 <= INFLIGHT;
                INFLIGHT: if (exit1) begin
                    state1    <= DONE;
                    res1_sum  <= u_sum;
                    res1_cout <= tag_cout[LAT-1];
                end
                DONE:     if (rsp1_ready) state1 <= IDLE;
                default:  state1 <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter with a behavioural add/sub unit
module tb_addsub_arbiter;
    localparam int N   = 8;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_sub, rsp0_valid, rsp0_ready, rsp0_cout;
    logic         req1_valid, req1_ready, req1_sub, rsp1_valid, rsp1_ready, rsp1_cout;
    logic [N-1:0] req0_a, req0_b, rsp0_sum, req1_a, req1_b, rsp1_sum;
    logic [N-1:0] u_a, u_b, u_sum;
    logic         u_cin, u_cout;
    logic [N:0]   unit_full;
    logic [N-1:0] upipe [LAT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
        .u_a(u_a), .u_b(u_b), .u_cin(u_cin), .u_sum(u_sum), .u_cout(u_cout)
    );

    // Shared unit: carry is combinational, sum emerges LAT cycles after issue.
    assign unit_full = {1'b0, u_a} + {1'b0, u_b ^ {N{u_cin}}} + {{N{1'b0}}, u_cin};
    assign u_cout    = unit_full[N];
    assign u_sum     = upipe[LAT-1];
    always @(posedge clk) begin
        upipe[0] <= unit_full[N-1:0];
        for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
    end

    task automatic idle_inputs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_sub = 0; rsp0_ready = 1;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_sub = 0; rsp1_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        req0_valid = 1; req0_a = 8'hAA; req0_b = 8'h55; req0_sub = 1; rsp0_ready = 0;
        req1_valid = 1; req1_a = 8'h11; req1_b = 8'h22; req1_sub = 1; rsp1_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready, u_a, u_b, u_cin} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_grant: got %0h, expected 0", {req0_ready, req1_ready, u_a, u_b, u_cin});
        end
        n_checks++;
        if ({rsp0_valid, rsp0_sum, rsp0_cout, rsp1_valid, rsp1_sum, rsp1_cout} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %0h, expected 0",
                     {rsp0_valid, rsp0_sum, rsp0_cout, rsp1_valid, rsp1_sum, rsp1_cout});
        end
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_sub_basic();
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'h05; req0_b = 8'h03; req0_sub = 1; rsp0_ready = 1;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, u_a, u_b, u_cin} !== {1'b1, 8'h05, 8'h03, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_issue: got %0h, expected %0h", {req0_ready, u_a, u_b, u_cin},
                     {1'b1, 8'h05, 8'h03, 1'b1});
        end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            req0_valid = 0;
            @(negedge clk);
            n_checks++;
            if (rsp0_valid !== (c == 3)) begin
                n_fail++;
                $display("FAIL basic_latency c%0d: got %b, expected %b", c, rsp0_valid, (c == 3));
            end
        end
        n_checks++;
        if ({rsp0_sum, rsp0_cout} !== {8'h02, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_result: got %0h, expected %0h", {rsp0_sum, rsp0_cout}, {8'h02, 1'b1});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_consumed: got %b, expected 0", rsp0_valid);
        end
    endtask

    task automatic test_arith();
        logic [7:0] va [6] = '{8'h03, 8'hFF, 8'h80, 8'h10, 8'h12, 8'h00};
        logic [7:0] vb [6] = '{8'h05, 8'h01, 8'h80, 8'h10, 8'h34, 8'h01};
        logic       vs [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [8:0] ve [6] = '{{8'hFE, 1'b0}, {8'h00, 1'b1}, {8'h00, 1'b1},
                               {8'h00, 1'b1}, {8'h46, 1'b0}, {8'hFF, 1'b0}};
        logic [9:0] rsp;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i % 2 == 0) begin
                req0_valid = 1; req0_a = va[i]; req0_b = vb[i]; req0_sub = vs[i];
            end else begin
                req1_valid = 1; req1_a = va[i]; req1_b = vb[i]; req1_sub = vs[i];
            end
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk); #1;
                req0_valid = 0; req1_valid = 0;
            end
            @(negedge clk);
            rsp = (i % 2 == 0) ? {rsp0_valid, rsp0_sum, rsp0_cout} : {rsp1_valid, rsp1_sum, rsp1_cout};
            n_checks++;
            if (rsp !== {1'b1, ve[i]}) begin
                n_fail++;
                $display("FAIL arith[%0d]: got %0h, expected %0h", i, rsp, {1'b1, ve[i]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] q0[$];
        logic [8:0] q1[$];
        logic [8:0] got;
        logic       g0, g1;
        int         n0 = 0;
        int         n1 = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            req0_valid = (c < 16); req0_a = 8'h10 + 8'(c); req0_b = 8'h01; req0_sub = 0;
            req1_valid = (c < 16); req1_a = 8'h40 + 8'(c); req1_b = 8'h50; req1_sub = 1;
            rsp0_ready = 1; rsp1_ready = 1;
            @(negedge clk);
            g0 = (c < 16) && (c % 4 == 0);
            g1 = (c < 16) && (c % 4 == 1);
            n_checks++;
            if ({req0_ready, req1_ready} !== {g0, g1}) begin
                n_fail++;
                $display("FAIL b2b_grant c%0d: got %b%b, expected %b%b", c, req0_ready, req1_ready, g0, g1);
            end
            if (g0) q0.push_back({8'h11 + 8'(c), 1'b0});
            if (g1) q1.push_back({8'hF0 + 8'(c), 1'b0});
            if (rsp0_valid) begin
                n0++;
                got = (q0.size() > 0) ? q0.pop_front() : 9'h1FF;
                n_checks++;
                if ({rsp0_sum, rsp0_cout} !== got) begin
                    n_fail++;
                    $display("FAIL b2b_rsp0 c%0d: got %0h, expected %0h", c, {rsp0_sum, rsp0_cout}, got);
                end
            end
            if (rsp1_valid) begin
                n1++;
                got = (q1.size() > 0) ? q1.pop_front() : 9'h1FF;
                n_checks++;
                if ({rsp1_sum, rsp1_cout} !== got) begin
                    n_fail++;
                    $display("FAIL b2b_rsp1 c%0d: got %0h, expected %0h", c, {rsp1_sum, rsp1_cout}, got);
                end
            end
        end
        n_checks++;
        if (n0 != 4 || n1 != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d/%0d results, expected 4/4", n0, n1);
        end
    endtask

    task automatic test_tie_rr();
        logic [1:0] eg;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            case (c)
                0: begin
                    rsp0_ready = 0; rsp1_ready = 0;
                    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_sub = 0;
                end
                1: begin req1_valid = 1; req1_a = 8'h07; req1_b = 8'h03; req1_sub = 1; end
                5: begin rsp0_ready = 1; rsp1_ready = 1; end
                6: begin
                    req0_a = 8'h0A; req0_b = 8'h0B; req0_sub = 0;
                    req1_a = 8'h0C; req1_b = 8'h0D; req1_sub = 1;
                end
                8: begin req0_valid = 0; req1_valid = 0; end
                default: ;
            endcase
            @(negedge clk);
            eg = (c == 0 || c == 6) ? 2'b10 : (c == 1 || c == 7) ? 2'b01 : 2'b00;
            n_checks++;
            if ({req0_ready, req1_ready} !== eg) begin
                n_fail++;
                $display("FAIL tie_grant c%0d: got %b%b, expected %b", c, req0_ready, req1_ready, eg);
            end
            if (c == 5) begin
                n_checks++;
                if ({rsp0_valid, rsp0_sum, rsp0_cout, rsp1_valid, rsp1_sum, rsp1_cout} !==
                    {1'b1, 8'h03, 1'b0, 1'b1, 8'h04, 1'b1}) begin
                    n_fail++;
                    $display("FAIL tie_held: got %0h, expected %0h",
                             {rsp0_valid, rsp0_sum, rsp0_cout, rsp1_valid, rsp1_sum, rsp1_cout},
                             {1'b1, 8'h03, 1'b0, 1'b1, 8'h04, 1'b1});
                end
            end
            if (c == 9 || c == 10) begin
                n_checks++;
                if ((c == 9 && {rsp0_valid, rsp0_sum, rsp0_cout} !== {1'b1, 8'h15, 1'b0}) ||
                    (c == 10 && {rsp1_valid, rsp1_sum, rsp1_cout} !== {1'b1, 8'hFF, 1'b0})) begin
                    n_fail++;
                    $display("FAIL tie_rsp c%0d: got %0h/%0h", c,
                             {rsp0_valid, rsp0_sum, rsp0_cout}, {rsp1_valid, rsp1_sum, rsp1_cout});
                end
            end
        end
    endtask

    task automatic test_stall();
        logic ex_r0;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            case (c)
                0: begin
                    rsp0_ready = 0; rsp1_ready = 1;
                    req0_valid = 1; req0_a = 8'h20; req0_b = 8'h07; req0_sub = 0;
                end
                1: begin
                    req0_a = 8'h55; req0_b = 8'h01;
                    req1_valid = 1; req1_a = 8'h09; req1_b = 8'h04; req1_sub = 1;
                end
                2: req1_valid = 0;
                8: rsp0_ready = 1;
                10: req0_valid = 0;
                default: ;
            endcase
            @(negedge clk);
            ex_r0 = (c == 0 || c == 9);
            n_checks++;
            if ({req0_ready, req1_ready} !== {ex_r0, c == 1}) begin
                n_fail++;
                $display("FAIL stall_grant c%0d: got %b%b, expected %b%b", c, req0_ready, req1_ready,
                         ex_r0, (c == 1));
            end
            if (c >= 3 && c <= 8) begin
                n_checks++;
                if ({rsp0_valid, rsp0_sum, rsp0_cout} !== {1'b1, 8'h27, 1'b0}) begin
                    n_fail++;
                    $display("FAIL stall_hold c%0d: got %0h, expected %0h", c,
                             {rsp0_valid, rsp0_sum, rsp0_cout}, {1'b1, 8'h27, 1'b0});
                end
            end
            if (c == 9 && u_a !== 8'h55) begin
                n_fail++;
                $display("FAIL stall_reissue: got u_a=%0h, expected 55", u_a);
            end
            if (c == 9) n_checks++;
            if (c == 4 || c == 5) begin
                n_checks++;
                if ({rsp1_valid, rsp1_sum, rsp1_cout} !== ((c == 4) ? {1'b1, 8'h05, 1'b1} : {rsp1_valid & 1'b0, rsp1_sum, rsp1_cout})) begin
                    n_fail++;
                    $display("FAIL stall_req1 c%0d: got %0h", c, {rsp1_valid, rsp1_sum, rsp1_cout});
                end
            end
            if (c == 12) begin
                n_checks++;
                if ({rsp0_valid, rsp0_sum, rsp0_cout} !== {1'b1, 8'h56, 1'b0}) begin
                    n_fail++;
                    $display("FAIL stall_second: got %0h, expected %0h",
                             {rsp0_valid, rsp0_sum, rsp0_cout}, {1'b1, 8'h56, 1'b0});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            case (c)
                0: begin
                    rsp0_ready = 1; rsp1_ready = 1;
                    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h01; req1_sub = 0;
                end
                1: rst = 1;
                2: begin rst = 0; req1_valid = 0; end
                8: begin req1_valid = 1; req1_a = 8'h30; req1_b = 8'h0F; req1_sub = 0; end
                9: req1_valid = 0;
                default: ;
            endcase
            @(negedge clk);
            n_checks++;
            if (req1_ready !== (c == 0 || c == 8)) begin
                n_fail++;
                $display("FAIL rstmid_grant c%0d: got %b, expected %b", c, req1_ready, (c == 0 || c == 8));
            end
            if (c == 1) begin
                n_checks++;
                if ({u_a, u_b, u_cin} !== 17'd0) begin
                    n_fail++;
                    $display("FAIL rstmid_unit: got %0h, expected 0", {u_a, u_b, u_cin});
                end
            end
            n_checks++;
            if (rsp1_valid !== (c == 11)) begin
                n_fail++;
                $display("FAIL rstmid_rsp c%0d: got %b, expected %b", c, rsp1_valid, (c == 11));
            end
            if (c == 11) begin
                n_checks++;
                if ({rsp1_sum, rsp1_cout} !== {8'h3F, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rstmid_result: got %0h, expected %0h", {rsp1_sum, rsp1_cout}, {8'h3F, 1'b0});
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sub_basic();
        test_arith();
        test_back_to_back();
        test_tie_rr();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
